// File: rtl/mult_arb_pkg.sv
// Shared types and constants for the mult_arb multiplier-sharing arbiter.
package mult_arb_pkg;

  localparam int unsigned OP_W     = 8;
  localparam int unsigned PROD_W   = 16;
  localparam int unsigned NREQ_MIN = 2;
  localparam int unsigned NREQ_MAX = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    PIPE = 2'd2,
    RESP = 2'd3
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } operands_t;

endpackage

// File: rtl/mult.sv
// Shared combinational 8x8 unsigned multiplier datapath.
module mult
  import mult_arb_pkg::*;
(
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [PROD_W-1:0] x
);

  assign x = PROD_W'(a) * PROD_W'(b);

endmodule

// File: rtl/mult_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module mult_rr_pick #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx
);

  logic           found;
  logic [IDW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IDW'((32'(ptr) + k) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    grant[idx] = found;
  end

endmodule

// File: rtl/mult_arb.sv
// Round-robin arbiter sharing one mult instance among NREQ requesters.
// Define MULT_ARB_PIPE_EN to add a PIPE state that re-registers the product.
module mult_arb
  import mult_arb_pkg::*;
#(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*OP_W-1:0] req_a,
  input  logic [NREQ*OP_W-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [PROD_W-1:0]    rsp_x,
  output logic                 busy
);

  if (NREQ < NREQ_MIN || NREQ > NREQ_MAX) begin : g_bad_nreq
    $error("mult_arb: NREQ out of range");
  end

  state_t            state, state_nxt;
  logic [IDW-1:0]    ptr, ptr_nxt, id, pick_idx;
  logic [NREQ-1:0]   pick_grant;
  operands_t         op, req_op;
  logic [PROD_W-1:0] prod, res;
  logic              load_op, load_res;

  mult_rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  mult u_mult (
    .a (op.a),
    .b (op.b),
    .x (prod)
  );

  assign req_op.a = req_a[OP_W*32'(pick_idx) +: OP_W];
  assign req_op.b = req_b[OP_W*32'(pick_idx) +: OP_W];
  assign ptr_nxt  = (pick_idx == IDW'(NREQ-1)) ? '0 : pick_idx + IDW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and handshake; grants only from IDLE, gated off while in reset.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    load_op   = 1'b0;
    load_res  = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n && (|req_valid)) begin
          req_ready = pick_grant;
          load_op   = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        load_res = 1'b1;
`ifdef MULT_ARB_PIPE_EN
        state_nxt = PIPE;
`else
        state_nxt = RESP;
`endif
      end
`ifdef MULT_ARB_PIPE_EN
      PIPE: state_nxt = RESP;
`else
      PIPE: state_nxt = IDLE;
`endif
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
      id  <= '0;
      op  <= '0;
      res <= '0;
    end else begin
      if (load_op) begin
        op  <= req_op;
        id  <= pick_idx;
        ptr <= ptr_nxt;
      end
      if (load_res) res <= prod;
    end
  end

`ifdef MULT_ARB_PIPE_EN
  logic [PROD_W-1:0] res2;

  // Second product stage gives a retimed multiplier an extra cycle.
  always_ff @(posedge clk) begin
    if (!rst_n)             res2 <= '0;
    else if (state == PIPE) res2 <= res;
  end

  assign rsp_x = res2;
`else
  assign rsp_x = res;
`endif

  assign rsp_valid = (state == RESP);
  assign rsp_id    = id;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mult_arb.sv
// Randomized and directed self-checking bench for mult_arb against a transaction-level model.
module tb_mult_arb;

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = $clog2(NREQ);
`ifdef MULT_ARB_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*8-1:0] req_a, req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [15:0]       rsp_x;
  logic              busy;

  mult_arb #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_x     (rsp_x),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // requester-side stimulus state
  logic       v  [NREQ];
  logic [7:0] ra [NREQ];
  logic [7:0] rb [NREQ];
  bit         hold_all = 0;

  // transaction model: one op in flight, response LAT edges after the grant edge
  int          m_ptr = 0;
  bit          m_busy = 0;
  int          m_since = 0;
  int          m_id = 0;
  logic [15:0] m_x = '0;
  int          gnt_log[$];
  int          gnt_cyc[$];
  int          cyc = 0;

  logic [15:0] obs_x;
  int          rise_cyc = 0;
  int          n_rsp = 0;
  logic        prev_v = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int pick(input int p, input logic [NREQ-1:0] vv);
    for (int k = 0; k < int'(NREQ); k++) begin
      int j = (p + k) % int'(NREQ);
      if (vv[j]) return j;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < int'(NREQ); i++) begin
      req_valid[i]     = v[i];
      req_a[i*8 +: 8]  = ra[i];
      req_b[i*8 +: 8]  = rb[i];
    end
  endtask

  // one clock: check outputs at negedge, advance the model at posedge
  task automatic cycle();
    logic [NREQ-1:0] exp_rdy;
    int g;
    bit exp_rv;
    drive();
    @(negedge clk);
    exp_rdy = '0;
    if (rst_n && !m_busy) begin
      g = pick(m_ptr, req_valid);
      if (g >= 0) exp_rdy[g] = 1'b1;
    end
    chk("req_ready", req_ready, exp_rdy);
    if (rst_n) begin
      exp_rv = m_busy && (m_since >= LAT);
      chk("busy", busy, m_busy);
      chk("rsp_valid", rsp_valid, exp_rv);
      if (exp_rv) begin
        chk("rsp_id", rsp_id, m_id);
        chk("rsp_x", rsp_x, m_x);
      end
      if (rsp_valid) n_rsp++;
      if (rsp_valid && !prev_v) rise_cyc = cyc;
      if (rsp_valid && rsp_ready) obs_x = rsp_x;
      prev_v = rsp_valid;
    end
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      m_busy = 0;
      m_ptr  = 0;
      prev_v = 1'b0;
    end else if (m_busy) begin
      if (m_since >= LAT && rsp_ready) m_busy = 0;
      else m_since++;
    end else begin
      g = pick(m_ptr, req_valid);
      if (g >= 0) begin
        m_busy  = 1;
        m_since = 1;
        m_id    = g;
        m_x     = 16'(ra[g]) * 16'(rb[g]);
        m_ptr   = (g + 1) % int'(NREQ);
        gnt_log.push_back(g);
        gnt_cyc.push_back(cyc);
        v[g] = hold_all;
        if (hold_all) begin
          ra[g] = 8'($urandom);
          rb[g] = 8'($urandom);
        end
      end
    end
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
    v[i] = 1'b1; ra[i] = a; rb[i] = b;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < int'(NREQ); i++) v[i] = 1'b0;
  endtask

  task automatic run_idle(input int limit);
    int n = 0;
    bit any;
    any = 1;
    while (any && n < limit) begin
      any = m_busy;
      for (int i = 0; i < int'(NREQ); i++) any |= v[i];
      if (any) begin cycle(); n++; end
    end
    if (n >= limit) chk("idle_timeout", n, 0);
  endtask

  task automatic do_reset();
    clear_reqs();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < int'(NREQ); i++) begin v[i] = 0; ra[i] = '0; rb[i] = '0; end
    repeat (3) cycle();
    rst_n = 1'b1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_x", rsp_x, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_busy", busy, 0);

    // single request on requester 0
    gnt_log.delete(); gnt_cyc.delete();
    set_req(0, 8'h03, 8'h05);
    run_idle(20);
    chk("single_x", obs_x, 16'h000F);
    chk("single_gnt", gnt_log[0], 0);
    chk("single_lat", rise_cyc - gnt_cyc[0], LAT - 1);

    // fairness with every requester continuously valid
    do_reset();
    gnt_log.delete(); gnt_cyc.delete();
    hold_all = 1;
    for (int i = 0; i < int'(NREQ); i++) set_req(i, 8'($urandom), 8'($urandom));
    for (int n = 0; n < 60 && gnt_log.size() < 5; n++) cycle();
    hold_all = 0;
    clear_reqs();
    run_idle(20);
    chk("fair_cnt", gnt_log.size(), 5);
    for (int k = 0; k < 5 && k < gnt_log.size(); k++) chk("fair_order", gnt_log[k], k % 4);
    for (int k = 0; k < 4 && k + 1 < gnt_cyc.size(); k++)
      chk("fair_interval", gnt_cyc[k+1] - gnt_cyc[k], LAT + 1);

    // pointer wrap: after req2, req3 precedes req1
    do_reset();
    set_req(2, 8'h11, 8'h22);
    run_idle(20);
    gnt_log.delete();
    set_req(1, 8'h07, 8'h09);
    set_req(3, 8'h0A, 8'h0B);
    run_idle(30);
    chk("wrap_cnt", gnt_log.size(), 2);
    chk("wrap_first", gnt_log[0], 3);
    chk("wrap_second", gnt_log[1], 1);

    // response backpressure with other requesters waiting
    rsp_ready = 1'b0;
    set_req(1, 8'hFF, 8'hFF);
    for (int n = 0; n < 10 && !(m_busy && m_since >= LAT); n++) cycle();
    set_req(0, 8'h01, 8'h02);
    set_req(2, 8'h03, 8'h04);
    for (int n = 0; n < 5; n++) begin
      cycle();
      chk("bp_x", rsp_x, 16'hFE01);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_busy", busy, 1);
      chk("bp_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    run_idle(30);

    // operand extremes
    set_req(2, 8'h00, 8'hA5);
    run_idle(20);
    chk("zero_x", obs_x, 16'h0000);
    set_req(3, 8'h80, 8'h02);
    run_idle(20);
    chk("pow2_x", obs_x, 16'h0100);

    // full A sweep on requester 1
    for (int i = 0; i < 256; i++) begin
      set_req(1, 8'(i), 8'($urandom));
      run_idle(20);
    end

    // reset while the operation is in CALC
    do_reset();
    set_req(2, 8'h33, 8'h44);
    for (int n = 0; n < 5 && !m_busy; n++) cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    n_rsp = 0;
    repeat (6) cycle();
    chk("rst_no_rsp", n_rsp, 0);
    gnt_log.delete();
    for (int i = 0; i < int'(NREQ); i++) set_req(i, 8'($urandom), 8'($urandom));
    run_idle(60);
    chk("rst_gnt_cnt", gnt_log.size(), 4);
    chk("rst_first_gnt", gnt_log[0], 0);

    // random traffic with random backpressure and legal pre-grant drops
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (!v[i] && ($urandom % 4 == 0)) set_req(i, 8'($urandom), 8'($urandom));
        else if (v[i] && ($urandom % 16 == 0)) v[i] = 1'b0;
      end
      rsp_ready = ($urandom % 3) != 0;
      cycle();
    end
    rsp_ready = 1'b1;
    run_idle(60);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
